// File: rtl/filter_inverse_block.sv
// Receive-side decoder for the shift-by-one filter chain: STAGES inverse stages in
// series rebuild {data, valid, parity}, and a wrapping counter tracks delivered words.

module filter_inverse_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    input  logic         v,
    input  logic         p,
    output logic [W-1:0] y_data,
    output logic         y_valid,
    output logic         y_parity
);
    // The forward stage emits a word's MSB as parity one cycle ahead of the shifted
    // data, so last cycle's parity is the MSB this word lost. It loads through bubbles.
    logic p_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q      <= 1'b0;
            y_data   <= '0;
            y_valid  <= 1'b0;
            y_parity <= 1'b0;
        end else begin
            p_q      <= p;
            y_data   <= {p_q, d[W-1:1]};
            y_parity <= d[0];
            y_valid  <= v;
        end
    end
endmodule

module filter_inverse_block #(
    parameter int STAGES = 2,
    parameter int W      = 16,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  io_x_data,
    input  logic          io_x_valid,
    input  logic          io_x_parity,
    output logic [W-1:0]  io_y_data,
    output logic          io_y_valid,
    output logic          io_y_parity,
    output logic [CW-1:0] io_count
);
    logic [W-1:0]  stg_data   [STAGES+1];
    logic          stg_valid  [STAGES+1];
    logic          stg_parity [STAGES+1];
    logic [CW-1:0] count_q;

    assign stg_data[0]   = io_x_data;
    assign stg_valid[0]  = io_x_valid;
    assign stg_parity[0] = io_x_parity;

    // Stage 0 undoes the outermost forward stage.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        filter_inverse_stage #(.W(W)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .d        (stg_data[i]),
            .v        (stg_valid[i]),
            .p        (stg_parity[i]),
            .y_data   (stg_data[i+1]),
            .y_valid  (stg_valid[i+1]),
            .y_parity (stg_parity[i+1])
        );
    end

    // Steps on the same edge that loads a 1 into the final valid register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (stg_valid[STAGES-1]) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign io_y_data   = stg_data[STAGES];
    assign io_y_valid  = stg_valid[STAGES];
    assign io_y_parity = stg_parity[STAGES];
    assign io_count    = count_q;
endmodule

// File: tb/tb_filter_inverse_block.sv
// Loopback bench: a 5-deep forward filter model feeds decoders of depth 1, 2 and 5,
// plus a depth-2 decoder with a 4-bit counter for the wrap case.

module tb_filter_inverse_block;
    localparam int W  = 16;
    localparam int TN = 24;
    localparam int NR = 10000;

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic [W-1:0] x_data   = '0;
    logic         x_valid  = 1'b0;
    logic         x_parity = 1'b0;

    always #5 clk = ~clk;

    // Forward encoder chain; stage k's parity output is its own input data MSB.
    logic [W-1:0] f_d [5];
    logic         f_v [5];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 5; k++) begin
                f_d[k] <= '0;
                f_v[k] <= 1'b0;
            end
        end else begin
            f_d[0] <= {x_data[W-2:0], x_parity};
            f_v[0] <= x_valid;
            f_d[1] <= {f_d[0][W-2:0], x_data[W-1]};
            f_v[1] <= f_v[0];
            for (int k = 2; k < 5; k++) begin
                f_d[k] <= {f_d[k-1][W-2:0], f_d[k-2][W-1]};
                f_v[k] <= f_v[k-1];
            end
        end
    end

    logic [W-1:0] y1_d, y2_d, y5_d, yw_d;
    logic         y1_v, y2_v, y5_v, yw_v;
    logic         y1_p, y2_p, y5_p, yw_p;
    logic [15:0]  c1, c2, c5;
    logic [3:0]   cw;

    filter_inverse_block #(.STAGES(1), .W(W), .CW(16)) dut1 (
        .clk(clk), .reset(reset),
        .io_x_data(f_d[0]), .io_x_valid(f_v[0]), .io_x_parity(x_data[W-1]),
        .io_y_data(y1_d), .io_y_valid(y1_v), .io_y_parity(y1_p), .io_count(c1));

    filter_inverse_block #(.STAGES(2), .W(W), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .io_x_data(f_d[1]), .io_x_valid(f_v[1]), .io_x_parity(f_d[0][W-1]),
        .io_y_data(y2_d), .io_y_valid(y2_v), .io_y_parity(y2_p), .io_count(c2));

    filter_inverse_block #(.STAGES(5), .W(W), .CW(16)) dut5 (
        .clk(clk), .reset(reset),
        .io_x_data(f_d[4]), .io_x_valid(f_v[4]), .io_x_parity(f_d[3][W-1]),
        .io_y_data(y5_d), .io_y_valid(y5_v), .io_y_parity(y5_p), .io_count(c5));

    filter_inverse_block #(.STAGES(2), .W(W), .CW(4)) dut_w (
        .clk(clk), .reset(reset),
        .io_x_data(f_d[1]), .io_x_valid(f_v[1]), .io_x_parity(f_d[0][W-1]),
        .io_y_data(yw_d), .io_y_valid(yw_v), .io_y_parity(yw_p), .io_count(cw));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Directed tables, indexed by cycle since the test's reset.
    logic [W-1:0] sd  [TN];
    logic         sv  [TN];
    logic         sp  [TN];
    logic         sr  [TN];
    logic         ev  [TN];
    logic [W-1:0] ed  [TN];
    logic         ep  [TN];
    logic         cdp [TN];
    logic [15:0]  ec  [TN];

    task automatic clear_tab();
        for (int c = 0; c < TN; c++) begin
            sd[c] = '0;  sv[c] = 1'b0; sp[c] = 1'b0; sr[c] = 1'b0;
            ev[c] = 1'b0; ed[c] = '0; ep[c] = 1'b0; cdp[c] = 1'b0; ec[c] = '0;
        end
    endtask

    task automatic stim(input int c, input logic [W-1:0] d, input logic v, input logic p);
        sd[c] = d; sv[c] = v; sp[c] = p;
    endtask

    task automatic expect_word(input int c, input logic [W-1:0] d, input logic p);
        ev[c] = 1'b1; ed[c] = d; ep[c] = p; cdp[c] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; x_data = '0; x_valid = 1'b0; x_parity = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_table(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            check_eq($sformatf("%s c%0d valid", name, c), 32'(y2_v), 32'(ev[c]));
            if (cdp[c]) begin
                check_eq($sformatf("%s c%0d data", name, c), 32'(y2_d), 32'(ed[c]));
                check_eq($sformatf("%s c%0d parity", name, c), 32'(y2_p), 32'(ep[c]));
            end
            check_eq($sformatf("%s c%0d count", name, c), 32'(c2), 32'(ec[c]));
            check_eq($sformatf("%s c%0d count4", name, c), 32'(cw), 32'(ec[c][3:0]));
            reset = sr[c]; x_data = sd[c]; x_valid = sv[c]; x_parity = sp[c];
            @(posedge clk); #1;
        end
        reset = 1'b0; x_data = '0; x_valid = 1'b0; x_parity = 1'b0;
    endtask

    logic         hv [NR];
    logic [W-1:0] hd [NR];
    logic         hp [NR];
    int           ecnt [3];

    task automatic sb_one(input string tag, input int s, input int c, input int idx,
                          input logic v, input logic [W-1:0] d, input logic p,
                          input logic [15:0] cnt);
        int   k;
        logic xv;
        k  = c - 2 * s;
        xv = (k >= 0) ? hv[k] : 1'b0;
        if (xv) ecnt[idx]++;
        check_eq($sformatf("%s c%0d valid", tag, c), 32'(v), 32'(xv));
        if (xv) begin
            check_eq($sformatf("%s c%0d data", tag, c), 32'(d), 32'(hd[k]));
            check_eq($sformatf("%s c%0d parity", tag, c), 32'(p), 32'(hp[k]));
        end
        check_eq($sformatf("%s c%0d count", tag, c), 32'(cnt), 32'(ecnt[idx] & 16'hFFFF));
    endtask

    initial begin
        do_reset();
        check_eq("reset y2 data", 32'(y2_d), 32'h0);
        check_eq("reset y2 valid", 32'(y2_v), 32'h0);
        check_eq("reset y2 parity", 32'(y2_p), 32'h0);
        check_eq("reset y2 count", 32'(c2), 32'h0);
        check_eq("reset y1 all", 32'({y1_d, y1_v, y1_p}), 32'h0);
        check_eq("reset y5 all", 32'({y5_d, y5_v, y5_p}), 32'h0);
        check_eq("reset yw all", 32'({yw_d, yw_v, yw_p, cw}), 32'h0);
        check_eq("reset counts", 32'({c1, c5}), 32'h0);

        // Single word round trip.
        clear_tab();
        stim(0, 16'hA5C3, 1'b1, 1'b1);
        expect_word(4, 16'hA5C3, 1'b1);
        for (int c = 0; c < TN; c++) ec[c] = (c >= 4) ? 16'd1 : 16'd0;
        do_reset();
        run_table("loop", 8);

        // Back-to-back words including all-zero/all-one neighbours.
        clear_tab();
        stim(0, 16'h0000, 1'b1, 1'b0);
        stim(1, 16'hFFFF, 1'b1, 1'b1);
        stim(2, 16'h8001, 1'b1, 1'b1);
        stim(3, 16'h7FFE, 1'b1, 1'b0);
        expect_word(4, 16'h0000, 1'b0);
        expect_word(5, 16'hFFFF, 1'b1);
        expect_word(6, 16'h8001, 1'b1);
        expect_word(7, 16'h7FFE, 1'b0);
        for (int c = 0; c < TN; c++) ec[c] = (c < 4) ? 16'd0 : (c < 8) ? 16'(c - 3) : 16'd4;
        do_reset();
        run_table("burst", 10);

        // Words separated by garbage bubbles.
        clear_tab();
        stim(0, 16'h1234, 1'b1, 1'b0);
        stim(1, 16'hDEAD, 1'b0, 1'b1);
        stim(2, 16'h5555, 1'b0, 1'b0);
        stim(3, 16'hBEEF, 1'b1, 1'b1);
        stim(4, 16'h0F0F, 1'b1, 1'b0);
        stim(5, 16'hFFFF, 1'b0, 1'b1);
        stim(6, 16'h8000, 1'b0, 1'b1);
        expect_word(4, 16'h1234, 1'b0);
        expect_word(7, 16'hBEEF, 1'b1);
        expect_word(8, 16'h0F0F, 1'b0);
        for (int c = 0; c < TN; c++) ec[c] = (c < 4) ? 16'd0 : (c < 7) ? 16'd1 : (c < 8) ? 16'd2 : 16'd3;
        do_reset();
        run_table("bubble", 11);

        // Reset during a burst, then a fresh word.
        clear_tab();
        for (int c = 0; c <= 10; c++) stim(c, W'(16'h1111 * c), 1'b1, c[0]);
        sr[10] = 1'b1;
        for (int c = 0; c <= 6; c++) expect_word(c + 4, W'(16'h1111 * c), c[0]);
        cdp[11] = 1'b1;
        stim(12, 16'h3C5A, 1'b1, 1'b1);
        expect_word(16, 16'h3C5A, 1'b1);
        for (int c = 0; c < TN; c++)
            ec[c] = (c < 4) ? 16'd0 : (c <= 10) ? 16'(c - 3) : (c < 16) ? 16'd0 : 16'd1;
        do_reset();
        run_table("midrst", 18);

        // 17 words: the 4-bit counter passes 15 -> 0 -> 1.
        clear_tab();
        for (int c = 0; c <= 16; c++) begin
            stim(c, W'(16'h0100 + c), 1'b1, c[0]);
            expect_word(c + 4, W'(16'h0100 + c), c[0]);
        end
        for (int c = 0; c < TN; c++) ec[c] = (c < 4) ? 16'd0 : (c <= 20) ? 16'(c - 3) : 16'd17;
        do_reset();
        run_table("wrap", 22);

        // Random traffic through all decoder depths.
        for (int i = 0; i < 3; i++) ecnt[i] = 0;
        do_reset();
        for (int c = 0; c < NR; c++) begin
            sb_one("rnd s1", 1, c, 0, y1_v, y1_d, y1_p, c1);
            sb_one("rnd s2", 2, c, 1, y2_v, y2_d, y2_p, c2);
            sb_one("rnd s5", 5, c, 2, y5_v, y5_d, y5_p, c5);
            x_data   = W'($urandom);
            x_valid  = ($urandom_range(99) < 70);
            x_parity = 1'($urandom);
            hd[c] = x_data; hv[c] = x_valid; hp[c] = x_parity;
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
